// File: rtl/bp_be_dcache_resp_checker.sv
// In-order D$ load-response checker: queues expected dwords, compares responses under a byte mask.
// Optional macro BP_BE_DCACHE_CHECKER_HALT_EN: the first mismatch or unexpected response halts the checker.
module bp_be_dcache_resp_checker #(
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned exp_els_p     = 8,
  parameter int unsigned timeout_p     = 4096,
  parameter int unsigned count_width_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               exp_v_i,
  output logic                               exp_ready_o,
  input  logic [data_width_p-1:0]            exp_data_i,
  input  logic [data_width_p/8-1:0]          exp_mask_i,
  input  logic                               end_i,
  input  logic                               resp_v_i,
  input  logic [data_width_p-1:0]            resp_data_i,
  output logic [count_width_p-1:0]           match_count_o,
  output logic [count_width_p-1:0]           mismatch_count_o,
  output logic                               error_o,
  output logic                               timeout_o,
  output logic                               done_o,
  output logic [$clog2(exp_els_p+1)-1:0]     pending_o
);

  localparam int unsigned mask_width_lp = data_width_p / 8;
  localparam int unsigned ptr_width_lp  = $clog2(exp_els_p);
  localparam int unsigned occ_width_lp  = $clog2(exp_els_p + 1);
  localparam int unsigned to_width_lp   = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  typedef enum logic [1:0] {e_run, e_drain, e_done, e_error} state_e;

  state_e                     state_q, state_n;
  logic [data_width_p-1:0]    data_mem_q [exp_els_p];
  logic [mask_width_lp-1:0]   mask_mem_q [exp_els_p];
  logic [ptr_width_lp-1:0]    wr_ptr_q, rd_ptr_q;
  logic [occ_width_lp-1:0]    occ_q, occ_n;
  logic [to_width_lp-1:0]     to_cnt_q, to_cnt_n;
  logic [count_width_p-1:0]   match_cnt_q, mismatch_cnt_q;
  logic                       error_q, timeout_q, done_q, ready_q;

  logic push, pop, unexp, match, mismatch, to_fire, halt_err, error_n;

  assign push  = exp_v_i & ready_q;
  assign pop   = resp_v_i & (occ_q != '0);
  assign unexp = resp_v_i & (occ_q == '0);

  // Byte-masked compare of the response against the head entry.
  always_comb begin
    match = 1'b1;
    for (int unsigned b = 0; b < mask_width_lp; b++) begin
      if (mask_mem_q[rd_ptr_q][b] &&
          (resp_data_i[8*b +: 8] != data_mem_q[rd_ptr_q][8*b +: 8])) begin
        match = 1'b0;
      end
    end
  end

  assign mismatch = pop & ~match;

`ifdef BP_BE_DCACHE_CHECKER_HALT_EN
  assign halt_err = mismatch | unexp;
`else
  assign halt_err = 1'b0;
`endif

  // Occupancy; a push into a full queue cannot happen because ready is low then.
  always_comb begin
    occ_n = occ_q;
    if (push && !pop) begin
      occ_n = occ_width_lp'(occ_q + 1'b1);
    end else if (!push && pop) begin
      occ_n = occ_width_lp'(occ_q - 1'b1);
    end
  end

  // Idle watchdog: counts cycles with pending entries and no response.
  always_comb begin
    to_fire  = 1'b0;
    to_cnt_n = '0;
    if ((occ_q != '0) && !resp_v_i) begin
      if (to_cnt_q == to_width_lp'(timeout_p - 1)) begin
        to_fire = 1'b1;
      end else begin
        to_cnt_n = to_width_lp'(to_cnt_q + 1'b1);
      end
    end
  end

  assign error_n = error_q | mismatch | unexp | to_fire;

  always_comb begin
    state_n = state_q;
    case (state_q)
      e_run: begin
        if (to_fire || halt_err) begin
          state_n = e_error;
        end else if (end_i) begin
          state_n = error_n ? e_error : e_drain;
        end
      end
      e_drain: begin
        if (to_fire || halt_err) begin
          state_n = e_error;
        end else if (occ_n == '0) begin
          state_n = error_n ? e_error : e_done;
        end
      end
      e_done: begin
        if (resp_v_i) begin
          state_n = e_error;
        end
      end
      e_error: state_n = e_error;
      default: state_n = e_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_run;
    end else begin
      state_q <= state_n;
    end
  end

  // Expectation storage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < exp_els_p; i++) begin
        data_mem_q[i] <= '0;
        mask_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= exp_data_i;
        mask_mem_q[wr_ptr_q] <= exp_mask_i;
        wr_ptr_q             <= ptr_width_lp'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_q <= ptr_width_lp'(rd_ptr_q + 1'b1);
      end
    end
  end

  // Counters, sticky flags and registered status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_q          <= '0;
      to_cnt_q       <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      error_q        <= 1'b0;
      timeout_q      <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      occ_q    <= occ_n;
      to_cnt_q <= to_cnt_n;
      if (pop && match && (match_cnt_q != '1)) begin
        match_cnt_q <= count_width_p'(match_cnt_q + 1'b1);
      end
      if ((mismatch || unexp) && (mismatch_cnt_q != '1)) begin
        mismatch_cnt_q <= count_width_p'(mismatch_cnt_q + 1'b1);
      end
      error_q   <= error_n;
      timeout_q <= timeout_q | to_fire;
      done_q    <= (state_n == e_done);
      ready_q   <= (occ_n != occ_width_lp'(exp_els_p)) && (state_n == e_run);
    end
  end

  assign exp_ready_o      = ready_q;
  assign match_count_o    = match_cnt_q;
  assign mismatch_count_o = mismatch_cnt_q;
  assign error_o          = error_q;
  assign timeout_o        = timeout_q;
  assign done_o           = done_q;
  assign pending_o        = occ_q;

endmodule

// File: tb/tb_bp_be_dcache_resp_checker.sv
// Directed + randomized bench for bp_be_dcache_resp_checker against a queue-based reference model.
module tb_bp_be_dcache_resp_checker;

  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned N  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          exp_v, exp_ready, end_p, resp_v;
  logic [DW-1:0] exp_data, resp_data;
  logic [MW-1:0] exp_mask;
  logic [CW-1:0] match_count, mismatch_count;
  logic          error, timeout, done;
  logic [PW-1:0] pending;

  bp_be_dcache_resp_checker #(
    .data_width_p(DW), .exp_els_p(N), .timeout_p(T), .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .exp_v_i(exp_v), .exp_ready_o(exp_ready), .exp_data_i(exp_data), .exp_mask_i(exp_mask),
    .end_i(end_p), .resp_v_i(resp_v), .resp_data_i(resp_data),
    .match_count_o(match_count), .mismatch_count_o(mismatch_count),
    .error_o(error), .timeout_o(timeout), .done_o(done), .pending_o(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of expectations plus the checker's observable status.
  logic [DW-1:0] mq_data[$];
  logic [MW-1:0] mq_mask[$];
  int m_match, m_mis, m_idle;
  bit m_err, m_to, m_done, m_ready, m_ended, m_dead;

  function automatic bit bytes_match(input logic [DW-1:0] e, input logic [MW-1:0] m,
                                     input logic [DW-1:0] r);
    for (int b = 0; b < int'(MW); b++)
      if (m[b] && (e[8*b +: 8] != r[8*b +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] head_data();
    return (mq_data.size() > 0) ? mq_data[0] : 64'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp_val);
    n_checks++;
    assert (obs === exp_val) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp_val);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pending"},  64'(pending),        64'(mq_data.size()));
    chk({tag, ".ready"},    64'(exp_ready),      64'(m_ready));
    chk({tag, ".match"},    64'(match_count),    64'(m_match));
    chk({tag, ".mismatch"}, 64'(mismatch_count), 64'(m_mis));
    chk({tag, ".error"},    64'(error),          64'(m_err));
    chk({tag, ".timeout"},  64'(timeout),        64'(m_to));
    chk({tag, ".done"},     64'(done),           64'(m_done));
  endtask

  task automatic model_reset();
    mq_data.delete(); mq_mask.delete();
    m_match = 0; m_mis = 0; m_idle = 0;
    m_err = 0; m_to = 0; m_done = 0; m_ready = 0; m_ended = 0; m_dead = 0;
  endtask

  // One clock: drive inputs now, advance the model, check just after the rising edge.
  task automatic step(input string tag, input bit ev, input logic [DW-1:0] ed, input logic [MW-1:0] em,
                      input bit en, input bit rv, input logic [DW-1:0] rd);
    int  sz;
    bit  push, unexp, mis, fire, halt;
    logic [DW-1:0] hd;
    logic [MW-1:0] hm;
    exp_v = ev; exp_data = ed; exp_mask = em; end_p = en; resp_v = rv; resp_data = rd;
    sz = mq_data.size();
    push = ev && m_ready;
    unexp = rv && (sz == 0);
    mis = 1'b0; fire = 1'b0;
    if (rv && sz > 0) begin
      hd = mq_data.pop_front(); hm = mq_mask.pop_front();
      if (bytes_match(hd, hm, rd)) begin
        if (m_match < 65535) m_match++;
      end else begin
        mis = 1'b1;
        if (m_mis < 65535) m_mis++;
      end
    end
    if (unexp && m_mis < 65535) m_mis++;
    if (push) begin mq_data.push_back(ed); mq_mask.push_back(em); end
    if (sz > 0 && !rv) begin
      if (m_idle == int'(T) - 1) begin fire = 1'b1; m_idle = 0; end
      else m_idle++;
    end else m_idle = 0;
    m_err = m_err | mis | unexp | fire;
    m_to  = m_to | fire;
`ifdef BP_BE_DCACHE_CHECKER_HALT_EN
    halt = mis | unexp;
`else
    halt = 1'b0;
`endif
    if (!m_dead) begin
      if (m_done) begin
        if (rv) begin m_dead = 1; m_done = 0; end
      end else if (fire || halt) begin
        m_dead = 1;
      end else if (!m_ended) begin
        if (en) begin
          if (m_err) m_dead = 1; else m_ended = 1;
        end
      end else if (mq_data.size() == 0) begin
        if (m_err) m_dead = 1; else m_done = 1;
      end
    end
    m_ready = !m_dead && !m_ended && !m_done && (mq_data.size() != N);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, '0, '0, 0, 0, '0);
  endtask

  // Async reset applied between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    exp_v = 0; end_p = 0; resp_v = 0; exp_data = '0; exp_mask = '0; resp_data = '0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    exp_v = 0; end_p = 0; resp_v = 0; exp_data = '0; exp_mask = '0; resp_data = '0;
    model_reset();
    #3;

    // Three matching responses then end -> done.
    do_reset("rst0");
    idle("s1.idle");
    step("s1.push0", 1, 64'h11, 8'hFF, 0, 0, '0);
    step("s1.push1", 1, 64'h22, 8'hFF, 0, 0, '0);
    step("s1.push2", 1, 64'h33, 8'hFF, 0, 0, '0);
    step("s1.resp0", 0, '0, '0, 0, 1, 64'h11);
    step("s1.resp1", 0, '0, '0, 0, 1, 64'h22);
    step("s1.resp2", 0, '0, '0, 0, 1, 64'h33);
    step("s1.end",   0, '0, '0, 1, 0, '0);
    idle("s1.drain");
    chk("s1.done_const",  64'(done), 64'd1);
    chk("s1.match_const", 64'(match_count), 64'd3);

    // Byte mask: upper half compared matches, full mask mismatches.
    do_reset("rst1");
    idle("s2.idle");
    step("s2.push_m", 1, 64'hDEADBEEF_00000000, 8'hF0, 0, 0, '0);
    step("s2.resp_m", 0, '0, '0, 0, 1, 64'hDEADBEEF_FFFFFFFF);
    chk("s2.match_const", 64'(match_count), 64'd1);
    step("s2.push_x", 1, 64'hDEADBEEF_00000000, 8'hFF, 0, 0, '0);
    step("s2.resp_x", 0, '0, '0, 0, 1, 64'hDEADBEEF_FFFFFFFF);
    chk("s2.mis_const", 64'(mismatch_count), 64'd1);
    chk("s2.err_const", 64'(error), 64'd1);

    // Fill to capacity, pop to reopen, then wrap the pointers.
    do_reset("rst2");
    for (int i = 0; i < 9; i++) step("s3.fill", 1, 64'(i), 8'hFF, 0, 0, '0);
    chk("s3.full_pending", 64'(pending), 64'd8);
    chk("s3.full_ready",   64'(exp_ready), 64'd0);
    step("s3.pop_full", 1, 64'h99, 8'hFF, 0, 1, head_data());
    chk("s3.reopen_ready", 64'(exp_ready), 64'd1);
    step("s3.wrap0", 1, 64'hA0, 8'hFF, 0, 1, head_data());
    step("s3.wrap1", 1, 64'hA1, 8'hFF, 0, 1, head_data());
    for (int i = 0; i < 8; i++) step("s3.drain", 0, '0, '0, 0, 1, head_data());
    chk("s3.match_const", 64'(match_count), 64'd10);

    // Unexpected response on an empty queue.
    do_reset("rst3");
    idle("s4.idle");
    step("s4.unexp", 0, '0, '0, 0, 1, 64'h1234);
    idle("s4.after");
    chk("s4.mis_const", 64'(mismatch_count), 64'd1);

    // Timeout with one entry pending; end afterwards never yields done.
    do_reset("rst4");
    idle("s5.idle");
    step("s5.push", 1, 64'h55, 8'hFF, 0, 0, '0);
    for (int i = 0; i < 18; i++) idle("s5.wait");
    chk("s5.to_const", 64'(timeout), 64'd1);
    step("s5.end", 0, '0, '0, 1, 0, '0);
    idle("s5.post0");
    idle("s5.post1");
    chk("s5.done_const", 64'(done), 64'd0);

    // Mid-run asynchronous reset discards queued entries.
    do_reset("rst5");
    idle("s6.idle");
    for (int i = 0; i < 4; i++) step("s6.push", 1, 64'(i + 16), 8'hFF, 0, 0, '0);
    do_reset("s6.async");
    idle("s6.release");
    chk("s6.pending_const", 64'(pending), 64'd0);
    chk("s6.ready_const",   64'(exp_ready), 64'd1);

    // Random traffic against the model, then end and drain.
    do_reset("rst6");
    idle("s7.idle");
    for (int i = 0; i < 400; i++) begin
      bit ev, rv;
      logic [DW-1:0] ed, rd;
      logic [MW-1:0] em;
      ev = ($urandom % 2) == 0;
      ed = {$urandom, $urandom};
      em = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      rv = ((mq_data.size() > 0) && (($urandom % 2) == 0)) || (($urandom % 100) == 0);
      rd = ((mq_data.size() > 0) && (($urandom % 4) != 0)) ? head_data() : {$urandom, $urandom};
      step("s7.rand", ev, ed, em, 0, rv, rd);
    end
    step("s7.end", 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < int'(N) + 2; i++)
      step("s7.drain", 0, '0, '0, 0, mq_data.size() > 0, head_data());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
